// File: rtl/mem_stage.sv
// Memory-access stage: registers ALU results, issues loads/stores over a req/ack port.
// Optional macro MEM_STAGE_TIMEOUT_EN aborts a memory wait after TIMEOUT_CYCLES cycles.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [6:0]  ex_opcode,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mem_err
);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        wbValid_q, wbValid_d, wbWe_q, wbWe_d, err_q, err_d;
    logic [4:0]  wbRd_q, wbRd_d, rd_q, rd_d;
    logic [31:0] wbData_q, wbData_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;

    logic        isLoad, isStore, funcOk, aligned, writesReg;
    logic [3:0]  beNext;
    logic [31:0] wdataNext, laneWord, loadVal;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
`endif

    assign ex_ready = (state_q == S_IDLE);

    always_comb begin
        isLoad    = (ex_opcode == 7'b0000011);
        isStore   = (ex_opcode == 7'b0100011);
        writesReg = (ex_opcode == 7'b0110011) || (ex_opcode == 7'b0010011) ||
                    (ex_opcode == 7'b0110111) || (ex_opcode == 7'b0010111);
        funcOk    = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010) ||
                    (isLoad && ((ex_funct3 == 3'b100) || (ex_funct3 == 3'b101)));
        aligned   = funcOk && ((ex_funct3[1:0] == 2'b00) ||
                               (ex_funct3[1:0] == 2'b01 && !ex_result[0]) ||
                               (ex_funct3[1:0] == 2'b10 && ex_result[1:0] == 2'b00));
        case (ex_funct3[1:0])
            2'b00: begin
                beNext    = 4'b0001 << ex_result[1:0];
                wdataNext = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                beNext    = ex_result[1] ? 4'b1100 : 4'b0011;
                wdataNext = {2{ex_store_data[15:0]}};
            end
            default: begin
                beNext    = 4'b1111;
                wdataNext = ex_store_data;
            end
        endcase
    end

    // The load lane is picked by shifting the returned word down to byte 0.
    always_comb begin
        laneWord = dmem_rdata >> {offset_q, 3'b000};
        case (funct3_q)
            3'b000:  loadVal = {{24{laneWord[7]}}, laneWord[7:0]};
            3'b001:  loadVal = {{16{laneWord[15]}}, laneWord[15:0]};
            3'b100:  loadVal = {24'b0, laneWord[7:0]};
            3'b101:  loadVal = {16'b0, laneWord[15:0]};
            default: loadVal = laneWord;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        wbValid_d = 1'b0;
        err_d     = 1'b0;
        wbWe_d    = wbWe_q;
        wbRd_d    = wbRd_q;
        wbData_d  = wbData_q;
        rd_d      = rd_q;
        funct3_d  = funct3_q;
        offset_d  = offset_q;
`ifdef MEM_STAGE_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    if (!(isLoad || isStore)) begin
                        wbValid_d = 1'b1;
                        wbWe_d    = writesReg && (ex_rd != 5'd0);
                        wbRd_d    = ex_rd;
                        wbData_d  = ex_result;
                    end else if (!aligned) begin
                        wbValid_d = 1'b1;
                        err_d     = 1'b1;
                        wbWe_d    = 1'b0;
                        wbRd_d    = ex_rd;
                        wbData_d  = ex_result;
                    end else begin
                        state_d  = S_WAIT;
                        req_d    = 1'b1;
                        we_d     = isStore;
                        addr_d   = {ex_result[31:2], 2'b00};
                        wdata_d  = wdataNext;
                        be_d     = beNext;
                        rd_d     = ex_rd;
                        funct3_d = ex_funct3;
                        offset_d = ex_result[1:0];
`ifdef MEM_STAGE_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end
                end
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    state_d   = S_IDLE;
                    req_d     = 1'b0;
                    wbValid_d = 1'b1;
                    wbRd_d    = rd_q;
                    wbWe_d    = !we_q && (rd_q != 5'd0);
                    wbData_d  = we_q ? 32'd0 : loadVal;
                end
`ifdef MEM_STAGE_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = S_IDLE;
                    req_d     = 1'b0;
                    wbValid_d = 1'b1;
                    err_d     = 1'b1;
                    wbRd_d    = rd_q;
                    wbWe_d    = 1'b0;
                    wbData_d  = {addr_q[31:2], offset_q};
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            wbValid_q <= 1'b0;
            wbWe_q    <= 1'b0;
            wbRd_q    <= '0;
            wbData_q  <= '0;
            err_q     <= 1'b0;
            rd_q      <= '0;
            funct3_q  <= '0;
            offset_q  <= '0;
`ifdef MEM_STAGE_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            wbValid_q <= wbValid_d;
            wbWe_q    <= wbWe_d;
            wbRd_q    <= wbRd_d;
            wbData_q  <= wbData_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
            funct3_q  <= funct3_d;
            offset_q  <= offset_d;
`ifdef MEM_STAGE_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign wb_valid   = wbValid_q;
    assign wb_we      = wbWe_q;
    assign wb_rd      = wbRd_q;
    assign wb_data    = wbData_q;
    assign mem_err    = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
        .ex_store_data(ex_store_data), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_rd(ex_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .mem_err(mem_err)
    );

    typedef struct {
        bit        req;
        bit        err;
        bit [3:0]  be;
        bit [31:0] wdata;
        bit        we;
        bit [31:0] data;
    } exp_t;

    // Expected outcome of one instruction, derived from access size and byte offset arithmetic.
    function automatic exp_t model(input bit [6:0] op, input bit [2:0] f3, input bit [31:0] res,
                                   input bit [31:0] st, input bit [4:0] rd, input bit [31:0] rdata);
        exp_t   e;
        bit     isLoad, isStore;
        int     size, off;
        longint v;
        e = '{default: 0};
        isLoad  = (op == 7'b0000011);
        isStore = (op == 7'b0100011);
        if (!isLoad && !isStore) begin
            e.data = res;
            e.we   = (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0110111 || op == 7'b0010111)
                     && rd != 0;
            return e;
        end
        size = 0;
        if (f3 == 0 || (isLoad && f3 == 4))      size = 1;
        else if (f3 == 1 || (isLoad && f3 == 5)) size = 2;
        else if (f3 == 2)                        size = 4;
        off = int'(res % 4);
        if (size == 0 || off % size != 0) begin
            e.err  = 1;
            e.data = res;
            return e;
        end
        e.req   = 1;
        e.be    = 4'(((1 << size) - 1) << off);
        e.wdata = (size == 1) ? st[7:0] * 32'h0101_0101 :
                  (size == 2) ? st[15:0] * 32'h0001_0001 : st;
        if (isStore) begin
            e.we   = 0;
            e.data = 0;
        end else begin
            v = longint'(rdata >> (8 * off));
            if (size < 4) v = v % (64'd1 << (8 * size));
            if (f3 < 4 && size < 4 && v >= longint'(64'd1 << (8 * size - 1)))
                v = v - longint'(64'd1 << (8 * size));
            e.data = 32'(v);
            e.we   = (rd != 0);
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one instruction at a negedge and follows it through to its writeback record.
    task automatic applyStimulus(input bit [6:0] op, input bit [2:0] f3, input bit [31:0] res,
                                 input bit [31:0] st, input bit [4:0] rd,
                                 input int ackDelay, input bit [31:0] rdata);
        exp_t e;
        e = model(op, f3, res, st, rd, rdata);
        checkOutput("ready_at_issue", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1;
        ex_opcode = op; ex_funct3 = f3; ex_result = res; ex_store_data = st; ex_rd = rd;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        ex_result = $urandom; ex_store_data = $urandom; ex_rd = 5'($urandom); ex_funct3 = 3'($urandom);
        @(negedge clk);
        if (!e.req) begin
            checkOutput("wb_valid", 32'(wb_valid), 32'd1);
            checkOutput("wb_we", 32'(wb_we), 32'(e.we));
            checkOutput("wb_rd", 32'(wb_rd), 32'(rd));
            checkOutput("wb_data", wb_data, e.data);
            checkOutput("mem_err", 32'(mem_err), 32'(e.err));
            checkOutput("no_req", 32'(dmem_req), 32'd0);
            checkOutput("ready_direct", 32'(ex_ready), 32'd1);
        end else begin
            checkOutput("req", 32'(dmem_req), 32'd1);
            checkOutput("req_we", 32'(dmem_we), 32'(op == 7'b0100011));
            checkOutput("req_addr", dmem_addr, res - (res % 4));
            checkOutput("req_be", 32'(dmem_be), 32'(e.be));
            if (op == 7'b0100011) checkOutput("req_wdata", dmem_wdata, e.wdata);
            checkOutput("ready_wait", 32'(ex_ready), 32'd0);
            checkOutput("wb_quiet", 32'(wb_valid), 32'd0);
            for (int i = 0; i < ackDelay; i++) begin
                @(negedge clk);
                checkOutput("req_held", 32'(dmem_req), 32'd1);
                checkOutput("addr_held", dmem_addr, res - (res % 4));
                checkOutput("ready_held", 32'(ex_ready), 32'd0);
                checkOutput("wb_quiet_wait", 32'(wb_valid), 32'd0);
            end
            dmem_ack = 1'b1;
            dmem_rdata = rdata;
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
            @(negedge clk);
            checkOutput("done_valid", 32'(wb_valid), 32'd1);
            checkOutput("done_req", 32'(dmem_req), 32'd0);
            checkOutput("done_we", 32'(wb_we), 32'(e.we));
            checkOutput("done_rd", 32'(wb_rd), 32'(rd));
            checkOutput("done_data", wb_data, e.data);
            checkOutput("done_err", 32'(mem_err), 32'd0);
            checkOutput("done_ready", 32'(ex_ready), 32'd1);
        end
    endtask

    bit [6:0] aluOps [7] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                             7'b1100011, 7'b1101111, 7'b0001111};

    initial begin
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_result = '0; ex_store_data = '0; ex_opcode = '0; ex_funct3 = '0; ex_rd = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        #1;
        checkOutput("rst_ready", 32'(ex_ready), 32'd1);
        checkOutput("rst_req", 32'(dmem_req), 32'd0);
        checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_mem_err", 32'(mem_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(7'b0110011, 3'b000, 32'h5, 32'h0, 5'd3, 0, 32'h0);
        applyStimulus(7'b0000011, 3'b000, 32'h103, 32'h0, 5'd7, 3, 32'h80FF_1234);
        applyStimulus(7'b0100011, 3'b001, 32'h202, 32'h0000_ABCD, 5'd0, 1, 32'h0);
        applyStimulus(7'b0000011, 3'b010, 32'h6, 32'h0, 5'd9, 0, 32'h0);
        applyStimulus(7'b0000011, 3'b101, 32'h2002, 32'h0, 5'd4, 0, 32'h8765_4321);
        applyStimulus(7'b0000011, 3'b011, 32'h2000, 32'h0, 5'd4, 0, 32'h0);

        // Two ALU results accepted on consecutive edges.
        ex_valid = 1'b1; ex_opcode = 7'b0010011; ex_result = 32'hAAAA_0001; ex_rd = 5'd1;
        @(posedge clk);
        #1;
        ex_opcode = 7'b0110111; ex_result = 32'hBBBB_0002; ex_rd = 5'd0;
        @(negedge clk);
        checkOutput("b2b_first_data", wb_data, 32'hAAAA_0001);
        checkOutput("b2b_first_we", 32'(wb_we), 32'd1);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_second_valid", 32'(wb_valid), 32'd1);
        checkOutput("b2b_second_data", wb_data, 32'hBBBB_0002);
        checkOutput("b2b_second_we", 32'(wb_we), 32'd0);
        @(negedge clk);
        checkOutput("b2b_idle_valid", 32'(wb_valid), 32'd0);

        // A stray ack while idle must not produce anything.
        dmem_ack = 1'b1;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        checkOutput("stray_ack_valid", 32'(wb_valid), 32'd0);
        checkOutput("stray_ack_req", 32'(dmem_req), 32'd0);

        // Reset while a load is outstanding discards it.
        ex_valid = 1'b1; ex_opcode = 7'b0000011; ex_funct3 = 3'b010; ex_result = 32'h400; ex_rd = 5'd5;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        @(negedge clk);
        checkOutput("rstwait_req", 32'(dmem_req), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstwait_req_drop", 32'(dmem_req), 32'd0);
        checkOutput("rstwait_ready", 32'(ex_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rstwait_no_wb", 32'(wb_valid), 32'd0);
            checkOutput("rstwait_idle_ready", 32'(ex_ready), 32'd1);
        end

        for (int n = 0; n < 120; n++) begin
            bit [6:0] op;
            int kind;
            kind = $urandom_range(0, 2);
            op = (kind == 0) ? aluOps[$urandom_range(0, 6)] :
                 (kind == 1) ? 7'b0000011 : 7'b0100011;
            applyStimulus(op, 3'($urandom), $urandom, $urandom, 5'($urandom),
                          $urandom_range(0, 3), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the RISC-V pipeline, directly downstream of the execute stage.
- Consumes the execute result (ALU value or effective address) together with opcode/funct3/rd, and performs loads and stores over a req/ack data-memory port.
- Produces one registered writeback record per accepted instruction.
- Back-pressures execute with ex_ready while a memory transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles waiting for dmem_ack before abort (used only with MEM_STAGE_TIMEOUT_EN).

Ports:
- clk  input  1  stage clock
- rst_n  input  1  reset, asynchronous, active-low
- ex_valid  input  1  execute output valid
- ex_ready  output  1  stage can accept this cycle
- ex_result  input  32  ALU result / effective address
- ex_store_data  input  32  rs2 value for stores
- ex_opcode  input  7  instruction opcode
- ex_funct3  input  3  access size/sign
- ex_rd  input  5  destination register
- dmem_req  output  1  memory request
- dmem_we  output  1  1=store, 0=load
- dmem_addr  output  32  word-aligned address ({ex_result[31:2],2'b00})
- dmem_wdata  output  32  store data, lane-replicated
- dmem_be  output  4  byte enables
- dmem_ack  input  1  memory completion, 1-cycle pulse
- dmem_rdata  input  32  load word, valid with dmem_ack
- wb_valid  output  1  writeback record valid (1-cycle pulse)
- wb_we  output  1  register write enable
- wb_rd  output  5  destination register
- wb_data  output  32  writeback value
- mem_err  output  1  misaligned/aborted access (1-cycle pulse, with wb_valid)

Behaviour:
- One clock, clk; reset is asynchronous and active-low (rst_n).
- Reset: all outputs 0 except ex_ready=1; FSM=IDLE. rst_n low mid-transaction drops dmem_req immediately and discards the transaction; no wb_valid is produced for it.
- FSM states: IDLE, WAIT.
- ex_ready = (state==IDLE). Accept = ex_valid && ex_ready.
- IDLE, accept, non-memory opcode:
  - Next cycle: wb_valid=1, wb_data=ex_result, wb_rd=ex_rd.
  - wb_we=1 for 0110011/0010011/0110111/0010111 with rd!=0; otherwise wb_we=0.
  - Latency 1; back-to-back accepts each cycle.
- IDLE, accept, load (0000011) or store (0100011), aligned:
  - Next cycle dmem_req=1 with addr/we/be/wdata registered; state -> WAIT. Latch rd, funct3, addr[1:0].
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0; byte always aligned.
  - Misaligned access: no dmem_req; next cycle wb_valid=1, wb_we=0, mem_err=1, wb_data=ex_result; stay IDLE.
- Store byte enables:
  - SB: be=1<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{rs2[15:0]}}.
  - SW: be=4'b1111, wdata=rs2.
- Load: be as for stores of the same size. funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others are treated as misaligned (mem_err).
- WAIT:
  - dmem_req and all dmem_* outputs held stable until dmem_ack.
  - dmem_ack only counts while dmem_req=1; ack seen in IDLE is ignored.
  - On ack: dmem_req=0 next cycle, state -> IDLE, wb_valid=1 same next cycle.
  - Load completion: wb_we=(rd!=0); wb_data = selected lane of dmem_rdata by addr[1:0], sign- or zero-extended per funct3.
  - Store completion: wb_we=0, wb_data=0.
- ack in the first cycle of dmem_req is legal: total load latency 2 cycles from accept.
- ex_ready is 0 throughout WAIT and returns to 1 in the cycle wb_valid pulses; a new accept is possible that same cycle.
- No combinational path from dmem_ack to dmem_req or to wb_*; all outputs are registered except ex_ready (decoded from state).

Optional Feature:
- Macro MEM_STAGE_TIMEOUT_EN.
- Defined: an 8..16-bit counter clears on entry to WAIT and increments each WAIT cycle without ack. On reaching TIMEOUT_CYCLES: dmem_req=0, state -> IDLE, next cycle wb_valid=1, wb_we=0, mem_err=1, wb_data=address. A later stray ack is ignored.
- Undefined: no counter; WAIT persists indefinitely until ack.

Test Plan:
- R-type: ex_opcode=0110011, ex_result=0x0000_0005, rd=3 -> next cycle wb_valid=1, wb_we=1, wb_rd=3, wb_data=5; ex_ready stays 1.
- LB: ex_opcode=0000011, funct3=000, ex_result=0x103, dmem_rdata=0x80FF_1234, ack 3 cycles after req -> dmem_addr=0x100, be=1000, wb_data=0xFFFF_FF80, ex_ready low during WAIT.
- SH: ex_opcode=0100011, funct3=001, ex_result=0x202, rs2=0x0000_ABCD -> dmem_we=1, be=1100, wdata=0xABCD_ABCD; on ack wb_valid=1, wb_we=0.
- Misaligned LW: ex_result=0x0000_0006 -> no dmem_req; next cycle wb_valid=1, mem_err=1, wb_we=0.
- Reset during WAIT: rst_n low 2 cycles after req -> dmem_req=0 immediately; after release ex_ready=1 and no wb_valid.
- MEM_STAGE_TIMEOUT_EN with TIMEOUT_CYCLES=4: load, no ack -> mem_err pulse on cycle 5 after req; a subsequent ack is ignored.
